// File: rtl/reg_bank_pkg.sv
// Shared register-bank constants used by the bank, pipeline and hazard units.
package reg_bank_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NRD_DEF    = 2;
    localparam int unsigned ZERO_REG   = 0;

endpackage

// File: rtl/reg_bank_rdport.sv
// One combinational read port: register mux, same-cycle write bypass and pending lookup.
module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [(1 << ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [(1 << ADDR_W)-1:0]             pending,
    input  logic [ADDR_W-1:0]                    rd_addr,
    input  logic                                 wr_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    output logic [DATA_W-1:0]                    rd_data,
    output logic                                 rd_pending
);

    logic addr_hit;
    logic is_zero;

    assign addr_hit = wr_en && (wr_addr == rd_addr);
    assign is_zero  = (rd_addr == ADDR_W'(ZERO_REG));

    // A write landing this cycle is forwarded and resolves the hazard.
    always_comb begin
        rd_data    = regs[rd_addr];
        rd_pending = pending[rd_addr] && !addr_hit;
        if (addr_hit && !is_zero) begin
            rd_data = wr_data;
        end
        if (is_zero) begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/reg_bank_sb.sv
// Register bank with integrated pending-writeback scoreboard and multiple bypassed read ports.
module reg_bank_sb
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NRD    = NRD_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_pending,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [ADDR_W:0]       pend_cnt
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0]             pending;
    logic [NREG-1:0]             pend_nxt;
    logic [CNT_W-1:0]            cnt_nxt;
    logic                        iss_v;
    logic                        wr_v;
    logic                        inc;
    logic                        dec;

    assign iss_v = iss_en && (iss_addr != ADDR_W'(ZERO_REG));
    assign wr_v  = wr_en && (wr_addr != ADDR_W'(ZERO_REG));

    // Issue wins over writeback on the same register; count moves only on real bit changes.
    always_comb begin
        pend_nxt = pending;
        cnt_nxt  = pend_cnt;
        inc      = 1'b0;
        dec      = 1'b0;
        if (wr_en) begin
            pend_nxt[wr_addr] = 1'b0;
        end
        if (iss_v) begin
            pend_nxt[iss_addr] = 1'b1;
        end
        pend_nxt[ZERO_REG] = 1'b0;
        inc = iss_v && !pending[iss_addr];
        dec = wr_v && pending[wr_addr] && !(iss_v && (iss_addr == wr_addr));
        if (inc && !dec) begin
            cnt_nxt = pend_cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt_nxt = pend_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs     <= '0;
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_v) begin
                regs[wr_addr] <= wr_data;
            end
            pending  <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        reg_bank_rdport #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_rdport (
            .regs      (regs),
            .pending   (pending),
            .rd_addr   (rd_addr[k*ADDR_W +: ADDR_W]),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .rd_data   (rd_data[k*DATA_W +: DATA_W]),
            .rd_pending(rd_pending[k])
        );
    end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed bench for reg_bank_sb: reads, bypass, scoreboard counting and asynchronous reset.
module tb_reg_bank_sb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NRD    = 2;

    logic                  clock;
    logic                  reset_n;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_pending;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  iss_en;
    logic [ADDR_W-1:0]     iss_addr;
    logic [ADDR_W:0]       pend_cnt;

    int n_tests;
    int n_fail;

    reg_bank_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NRD   (NRD)
    ) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_pending(rd_pending),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .pend_cnt  (pend_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rdd(input int k);
        return rd_data[k*DATA_W +: DATA_W];
    endfunction

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        #2;
        check("reset_cnt", 32'(pend_cnt), 32'd0);
        check("reset_rd0", rdd(0), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // write then read, r0 write ignored
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        wr_addr = 5'd0; wr_data = 32'h0000_1234;
        step();
        wr_en = 1'b0;
        set_rd(5'd5, 5'd0);
        check("wr_r5", rdd(0), 32'hDEADBEEF);
        check("wr_r0", rdd(1), 32'd0);

        // same-cycle bypass on both ports
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        set_rd(5'd7, 5'd7);
        check("byp_p1", rdd(1), 32'hA5A5A5A5);
        check("byp_p0", rdd(0), 32'hA5A5A5A5);
        step();
        wr_en = 1'b0; wr_data = 32'h0;
        set_rd(5'd7, 5'd5);
        check("byp_stored", rdd(0), 32'hA5A5A5A5);

        // scoreboard issue / writeback
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        iss_addr = 5'd9;
        step();
        iss_en = 1'b0;
        set_rd(5'd3, 5'd3);
        check("sb_cnt2", 32'(pend_cnt), 32'd2);
        check("sb_pend_r3", 32'(rd_pending), 32'b11);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        check("sb_hazard_res", 32'(rd_pending), 32'b00);
        step();
        wr_en = 1'b0;
        set_rd(5'd3, 5'd9);
        check("sb_cnt1", 32'(pend_cnt), 32'd1);
        check("sb_pend_after", 32'(rd_pending), 32'b10);

        // simultaneous issue and writeback on a pending register
        iss_en = 1'b1; iss_addr = 5'd4;
        step();
        check("sim_cnt_pre", 32'(pend_cnt), 32'd2);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        step();
        iss_en = 1'b0; wr_en = 1'b0;
        set_rd(5'd4, 5'd4);
        check("sim_cnt", 32'(pend_cnt), 32'd2);
        check("sim_data", rdd(0), 32'h44);
        check("sim_pend", 32'(rd_pending), 32'b11);

        // mid-run asynchronous reset, with a write and issue held during reset
        #2;
        reset_n = 1'b0;
        set_rd(5'd5, 5'd4);
        check("rst_cnt", 32'(pend_cnt), 32'd0);
        check("rst_r5", rdd(0), 32'd0);
        check("rst_r4", rdd(1), 32'd0);
        check("rst_pend", 32'(rd_pending), 32'b00);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFE;
        iss_en = 1'b1; iss_addr = 5'd6;
        step();
        wr_en = 1'b0; iss_en = 1'b0;
        reset_n = 1'b1;
        set_rd(5'd6, 5'd6);
        check("rst_drop_wr", rdd(0), 32'd0);
        check("rst_drop_pend", 32'(rd_pending), 32'b00);
        step();
        check("rst_drop_cnt", 32'(pend_cnt), 32'd0);

        // count boundary
        iss_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            iss_addr = ADDR_W'(i);
            step();
        end
        check("bnd_cnt31", 32'(pend_cnt), 32'd31);
        iss_addr = 5'd31;
        step();
        check("bnd_reissue", 32'(pend_cnt), 32'd31);
        iss_addr = 5'd0;
        step();
        iss_en = 1'b0;
        set_rd(5'd0, 5'd31);
        check("bnd_r0", 32'(pend_cnt), 32'd31);
        check("bnd_r0_pend", 32'(rd_pending), 32'b10);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h31;
        step();
        check("bnd_wb", 32'(pend_cnt), 32'd30);
        step();
        wr_en = 1'b0;
        check("bnd_wb_nonpend", 32'(pend_cnt), 32'd30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank_sb.md
REG_BANK_SB -- requirements
Module: reg_bank_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width (2**ADDR_W registers).
REQ-003 The block SHALL have parameter NRD, default 2, number of read ports.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port rd_addr, input, NRD*ADDR_W, packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-007 The block SHALL have port rd_data, output, NRD*DATA_W, packed read data.
REQ-008 The block SHALL have port rd_pending, output, NRD, per-port flag: the addressed register awaits writeback.
REQ-009 The block SHALL have port wr_en, input, 1, writeback strobe.
REQ-010 The block SHALL have port wr_addr, input, ADDR_W, writeback destination.
REQ-011 The block SHALL have port wr_data, input, DATA_W, writeback data.
REQ-012 The block SHALL have port iss_en, input, 1, issue strobe that marks a destination pending.
REQ-013 The block SHALL have port iss_addr, input, ADDR_W, issued destination.
REQ-014 The block SHALL have port pend_cnt, output, ADDR_W+1, number of registers currently pending.

Function
REQ-015 The block SHALL hold 2**ADDR_W registers of DATA_W bits plus one pending bit per register.
REQ-016 The block SHALL hard-wire register 0: reads return 0, writes are ignored, and its pending bit is never set.
REQ-017 The block SHALL write wr_data into register wr_addr at the clock edge when wr_en=1 and wr_addr!=0.
REQ-018 The block SHALL drive reads combinationally with zero latency.
REQ-019 The block SHALL bypass same-cycle writes: when wr_en=1 and rd_addr[k]==wr_addr!=0, rd_data[k] = wr_data.
REQ-020 The block SHALL set pending[iss_addr] at the edge when iss_en=1 and iss_addr!=0.
REQ-021 The block SHALL clear pending[wr_addr] at the edge when wr_en=1.
REQ-022 The block SHALL give set priority when iss_en and wr_en target the same register in the same cycle: the register is written and its pending bit ends at 1.
REQ-023 The block SHALL drive rd_pending[k] = pending[rd_addr[k]] AND NOT (wr_en AND wr_addr==rd_addr[k]), i.e. a same-cycle writeback resolves the hazard.
REQ-024 The block SHALL register pend_cnt, updated each edge by +1, -1 or 0 according to the net set/clear of pending bits; re-issuing an already-pending register or writing back a non-pending register SHALL NOT change the count.
REQ-025 The block SHALL keep pend_cnt within 0..2**ADDR_W-1 (register 0 is excluded); no wrap-around is possible.
REQ-026 The block SHALL serve multiple read ports at the same address identically.

Reset
REQ-027 The block SHALL, while reset_n=0, asynchronously clear all registers to 0, all pending bits to 0 and pend_cnt to 0.
REQ-028 The block SHALL discard any issue or write presented in a cycle in which reset_n is low, including writes already in flight.
REQ-029 The block SHALL resume normal operation on the first rising clock edge after reset_n deasserts.

Structure
REQ-030 The block SHALL take default widths and the zero-register index from a shared package, reg_bank_pkg, which also serves the pipeline and hazard units.
REQ-031 The block SHALL use one sub-module, reg_bank_rdport, per read port, instantiated NRD times by a generate loop; each instance contains the address mux, the bypass logic and the pending lookup.
REQ-032 The implementation SHALL be synthesizable, with no latches and no combinational loops.

Verification
REQ-033 The bench SHALL cover reset: pulse reset_n low mid-run after writes -> all registers read 0, rd_pending=0 and pend_cnt=0 immediately, before any clock edge.
REQ-034 The bench SHALL cover write then read: write 0xDEADBEEF to r5 -> the next cycle rd_addr[0]=5 returns 0xDEADBEEF; writing 0x1234 to r0 -> r0 still reads 0.
REQ-035 The bench SHALL cover bypass: in the same cycle, wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5 and rd_addr[1]=7 -> rd_data[1]=0xA5A5A5A5 before the edge.
REQ-036 The bench SHALL cover the scoreboard: issue r3 and then r9 -> pend_cnt=2 and rd_pending for r3 =1; write back r3 -> pend_cnt=1 and rd_pending for r3 =0.
REQ-037 The bench SHALL cover simultaneous events: r4 pending, then in one cycle iss_en and wr_en both target r4 -> r4 is written, remains pending, and pend_cnt is unchanged.
REQ-038 The bench SHALL cover the count boundary: issue r1..r31 -> pend_cnt=31; re-issue r31 -> pend_cnt stays 31; issue r0 -> no change.
